// File: rtl/vector_writeback_stage.sv
// vector_writeback_stage
//
// Writeback stage behind the vector floating-point execution units, including
// the sign-injection unit. An incoming raw vd result is merged with the old
// destination contents using vl, vm/v0 and SEW. The merged result is queued in
// a small FIFO and offered to the vector register file write port over a
// valid/ready handshake. Occupied FIFO entries are also searched by address
// so that issue logic can detect RAW hazards.
//
// Optional feature macro: DRAGONFANG_WB_TAIL_AGNOSTIC_EN
//   defined   : when in_vta=1, tail elements are written as all-ones.
//   undefined : in_vta is ignored and tail elements keep in_vd_old.
//
// Ports:
//   clock, n_reset          rising-edge clock, synchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready = FIFO not full)
//   in_vd, in_vd_old        raw result and current destination contents
//   in_vd_address           destination register index
//   in_sew                  0 = SEW32, 1 = SEW64
//   in_vl                   active vector length, clamped to the element count
//   in_vm, in_v0            unmasked flag and mask bits (element i uses bit i)
//   in_vta                  tail-agnostic request
//   wb_valid / wb_ready     register-file write handshake
//   wb_address, wb_data     head entry of the FIFO
//   hazard_address/_hit     RAW query against every occupied entry
//   occupancy               number of entries held
module vector_writeback_stage #(
  parameter int VLEN     = 64,
  parameter int DEPTH    = 2,
  parameter int VL_WIDTH = 7
) (
  input  logic                       clock,
  input  logic                       n_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [VLEN-1:0]            in_vd,
  input  logic [VLEN-1:0]            in_vd_old,
  input  logic [4:0]                 in_vd_address,
  input  logic                       in_sew,
  input  logic [VL_WIDTH-1:0]        in_vl,
  input  logic                       in_vm,
  input  logic [VLEN/32-1:0]         in_v0,
  input  logic                       in_vta,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_address,
  output logic [VLEN-1:0]            wb_data,
  input  logic [4:0]                 hazard_address,
  output logic                       hazard_hit,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int N32   = VLEN / 32;
  localparam int N64   = VLEN / 64;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [VLEN-1:0]  data_r [DEPTH];
  logic [4:0]       addr_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [OCC_W-1:0] occ_r;

  logic [VLEN-1:0]  merged_s;
  logic             push_s;
  logic             pop_s;
  logic             hit_s;
  logic             unused_vta_s;

  // Per-element merge of the raw result with the old destination contents.
  always_comb begin
    merged_s     = in_vd_old;
    unused_vta_s = in_vta;
    if (in_sew == 1'b0) begin
      for (int i = 0; i < N32; i++) begin
        if (i < int'(in_vl)) begin
          if (in_vm || in_v0[i]) begin
            merged_s[i*32 +: 32] = in_vd[i*32 +: 32];
          end else begin
            merged_s[i*32 +: 32] = in_vd_old[i*32 +: 32];
          end
        end else begin
`ifdef DRAGONFANG_WB_TAIL_AGNOSTIC_EN
          if (in_vta) begin
            merged_s[i*32 +: 32] = {32{1'b1}};
          end else begin
            merged_s[i*32 +: 32] = in_vd_old[i*32 +: 32];
          end
`else
          merged_s[i*32 +: 32] = in_vd_old[i*32 +: 32];
`endif
        end
      end
    end else begin
      for (int i = 0; i < N64; i++) begin
        if (i < int'(in_vl)) begin
          if (in_vm || in_v0[i]) begin
            merged_s[i*64 +: 64] = in_vd[i*64 +: 64];
          end else begin
            merged_s[i*64 +: 64] = in_vd_old[i*64 +: 64];
          end
        end else begin
`ifdef DRAGONFANG_WB_TAIL_AGNOSTIC_EN
          if (in_vta) begin
            merged_s[i*64 +: 64] = {64{1'b1}};
          end else begin
            merged_s[i*64 +: 64] = in_vd_old[i*64 +: 64];
          end
`else
          merged_s[i*64 +: 64] = in_vd_old[i*64 +: 64];
`endif
        end
      end
    end
  end

  // in_ready depends only on registered occupancy, never on wb_ready, so a
  // full FIFO cannot accept even while it is being drained.
  assign in_ready   = (occ_r < OCC_W'(DEPTH));
  assign wb_valid   = (occ_r != {OCC_W{1'b0}});
  assign wb_address = addr_r[head_r];
  assign wb_data    = data_r[head_r];
  assign occupancy  = occ_r;
  assign hazard_hit = hit_s;

  // A vl=0 result completes its handshake but is not enqueued.
  assign push_s = in_valid && in_ready && (in_vl != {VL_WIDTH{1'b0}});
  assign pop_s  = wb_valid && wb_ready;

  // RAW hazard search; the entry being popped this cycle is still valid here.
  always_comb begin
    hit_s = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if (valid_r[j] && (addr_r[j] == hazard_address)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        data_r[j] <= {VLEN{1'b0}};
        addr_r[j] <= 5'd0;
      end
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else begin
      // Push and pop never target the same slot: that would need the FIFO
      // to be both empty (nothing to pop) and full (no push accepted).
      if (push_s) begin
        data_r[tail_r]  <= merged_s;
        addr_r[tail_r]  <= in_vd_address;
        valid_r[tail_r] <= 1'b1;
        tail_r          <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_writeback_stage.sv
// Self-checking bench for vector_writeback_stage (VLEN=64, DEPTH=2).
// A queue-based reference model predicts every handshake and output.
module tb_vector_writeback_stage;

  localparam int VLEN  = 64;
  localparam int DEPTH = 2;

  logic        clock;
  logic        n_reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vd;
  logic [63:0] in_vd_old;
  logic [4:0]  in_vd_address;
  logic        in_sew;
  logic [6:0]  in_vl;
  logic        in_vm;
  logic [1:0]  in_v0;
  logic        in_vta;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_address;
  logic [63:0] wb_data;
  logic [4:0]  hazard_address;
  logic        hazard_hit;
  logic [1:0]  occupancy;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  vector_writeback_stage #(.VLEN(VLEN), .DEPTH(DEPTH), .VL_WIDTH(7)) dut (
    .clock(clock), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vd(in_vd), .in_vd_old(in_vd_old), .in_vd_address(in_vd_address),
    .in_sew(in_sew), .in_vl(in_vl), .in_vm(in_vm), .in_v0(in_v0),
    .in_vta(in_vta),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_address(wb_address), .wb_data(wb_data),
    .hazard_address(hazard_address), .hazard_hit(hazard_hit),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference merge using element masks: body active -> vd, masked -> old,
  // tail -> old (or all-ones when tail-agnostic is built in and requested).
  function automatic logic [63:0] ref_merge(input logic [63:0] vd, input logic [63:0] old,
                                            input logic sew, input int vl, input logic vm,
                                            input logic [1:0] v0, input logic vta);
    int          w;
    int          n;
    int          evl;
    logic [63:0] r;
    logic [63:0] m;
    w   = sew ? 64 : 32;
    n   = 64 / w;
    evl = (vl > n) ? n : vl;
    r   = old;
    for (int e = 0; e < n; e++) begin
      m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'h0000_0000_FFFF_FFFF << (e * 32));
      if (e < evl) begin
        if (vm || v0[e]) r = (r & ~m) | (vd & m);
      end else begin
`ifdef DRAGONFANG_WB_TAIL_AGNOSTIC_EN
        if (vta) r = r | m;
`endif
      end
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [63:0] vd, input logic [63:0] old,
                       input logic [4:0] a, input logic sew, input logic [6:0] vl,
                       input logic vm, input logic [1:0] v0, input logic vta);
    in_valid = v; in_vd = vd; in_vd_old = old; in_vd_address = a;
    in_sew = sew; in_vl = vl; in_vm = vm; in_v0 = v0; in_vta = vta;
  endtask

  // One clock: predict with the model, advance, then compare outputs.
  task automatic tick();
    bit   exp_ready;
    bit   push_m;
    bit   pop_m;
    bit   rst_m;
    bit   hit_m;
    ent_t e;
    exp_ready = (q.size() < DEPTH);
    check("in_ready", in_ready, exp_ready);
    rst_m  = !n_reset;
    pop_m  = !rst_m && q.size() != 0 && wb_ready;
    push_m = !rst_m && in_valid && exp_ready && in_vl != 7'd0;
    e.a = in_vd_address;
    e.d = ref_merge(in_vd, in_vd_old, in_sew, int'(in_vl), in_vm, in_v0, in_vta);
    @(posedge clock);
    #1;
    if (rst_m) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(e);
    end
    check("occupancy", occupancy, q.size());
    check("wb_valid", wb_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("wb_address", wb_address, q[0].a);
      check("wb_data", wb_data, q[0].d);
    end
    hit_m = 1'b0;
    foreach (q[k]) if (q[k].a == hazard_address) hit_m = 1'b1;
    check("hazard_hit", hazard_hit, hit_m);
  endtask

  initial begin
    n_reset = 1'b0; wb_ready = 1'b0; hazard_address = 5'd0;
    drive(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 7'd0, 1'b1, 2'b00, 1'b0);
    @(posedge clock); #1;
    tick();
    n_reset = 1'b1;
    check("rst_occupancy", occupancy, 64'd0);
    check("rst_wb_valid", wb_valid, 64'd0);
    check("rst_in_ready", in_ready, 64'd1);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_address", wb_address, 64'd0);
    check("rst_hazard_hit", hazard_hit, 64'd0);

    // Unmasked SEW32, full vl.
    drive(1'b1, 64'h1111_2222_3333_4444, 64'hAAAA_AAAA_BBBB_BBBB, 5'd7, 1'b0, 7'd2, 1'b1, 2'b00, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t1_valid", wb_valid, 64'd1);
    check("t1_data", wb_data, 64'h1111_2222_3333_4444);
    check("t1_addr", wb_address, 64'd7);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Masked element 1.
    drive(1'b1, 64'h1111_2222_3333_4444, 64'hAAAA_AAAA_BBBB_BBBB, 5'd9, 1'b0, 7'd2, 1'b0, 2'b01, 1'b0);
    tick();
    in_valid = 1'b0;
    check("t2_data", wb_data, 64'hAAAA_AAAA_3333_4444);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Tail element with vta.
    drive(1'b1, 64'h1111_2222_3333_4444, 64'hAAAA_AAAA_BBBB_BBBB, 5'd10, 1'b0, 7'd1, 1'b1, 2'b00, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef DRAGONFANG_WB_TAIL_AGNOSTIC_EN
    check("t3_data", wb_data, 64'hFFFF_FFFF_3333_4444);
`else
    check("t3_data", wb_data, 64'hAAAA_AAAA_3333_4444);
`endif
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;

    // Back-to-back pushes 3, 4, 5 with the write port stalled.
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd3, 1'b1, 7'd1, 1'b1, 2'b00, 1'b0);
    tick();
    in_vd_address = 5'd4; tick();
    in_vd_address = 5'd5;
    check("full_in_ready", in_ready, 64'd0);
    check("full_occupancy", occupancy, 64'd2);
    tick();
    hazard_address = 5'd4; #1;
    check("haz_4", hazard_hit, 64'd1);
    hazard_address = 5'd5; #1;
    check("haz_5", hazard_hit, 64'd0);
    check("drain_0", wb_address, 64'd3);
    wb_ready = 1'b1;
    tick();
    check("drain_1", wb_address, 64'd4);
    tick();
    in_valid = 1'b0;
    check("drain_2", wb_address, 64'd5);
    tick();
    check("drained", occupancy, 64'd0);
    wb_ready = 1'b0;

    // vl = 0 completes but enqueues nothing.
    drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 5'd12, 1'b0, 7'd0, 1'b1, 2'b00, 1'b0);
    check("vl0_ready", in_ready, 64'd1);
    tick();
    in_valid = 1'b0;
    check("vl0_valid", wb_valid, 64'd0);
    check("vl0_occ", occupancy, 64'd0);

    // Reset while two entries are held, with a push attempted in the reset cycle.
    drive(1'b1, 64'h5555_6666_7777_8888, 64'd0, 5'd20, 1'b0, 7'd2, 1'b1, 2'b00, 1'b0);
    tick(); tick();
    hazard_address = 5'd20;
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1; in_valid = 1'b0;
    check("rst2_occ", occupancy, 64'd0);
    check("rst2_valid", wb_valid, 64'd0);
    check("rst2_ready", in_ready, 64'd1);
    check("rst2_hit", hazard_hit, 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 1) != 0,
            {$urandom, $urandom}, {$urandom, $urandom},
            5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
            7'($urandom_range(0, 4)), $urandom_range(0, 1) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
      wb_ready       = $urandom_range(0, 2) != 0;
      hazard_address = 5'($urandom_range(0, 7));
      n_reset        = $urandom_range(0, 49) != 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_writeback_stage.md
Name: vector_writeback_stage

Overview:
- Downstream stage of the vector floating-point execution units, including the sign-injection unit.
- Takes a unit's raw vd result and merges it with the old destination contents according to vl, vm/v0 and SEW.
- Queues merged results in a small FIFO and presents them to the vector register file write port over a valid/ready handshake.
- Tracks in-flight destination registers so issue logic can detect RAW hazards.

Parameters:
- VLEN, 64: vector register width in bits; multiple of 64.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- VL_WIDTH, 7: width of vl input; must hold VLEN/32.

Ports:
- clock  input  1  rising-edge clock.
- n_reset  input  1  synchronous active-low reset.
- in_valid  input  1  result presented.
- in_ready  output  1  stage can accept.
- in_vd  input  VLEN  raw result from execution unit.
- in_vd_old  input  VLEN  current destination register contents.
- in_vd_address  input  5  destination register index.
- in_sew  input  1  0 = SEW32, 1 = SEW64.
- in_vl  input  VL_WIDTH  active vector length in elements.
- in_vm  input  1  1 = unmasked.
- in_v0  input  VLEN/32  mask bits, element i uses bit i.
- in_vta  input  1  tail-agnostic request.
- wb_valid  output  1  write pending.
- wb_ready  input  1  register file accepts.
- wb_address  output  5  write index.
- wb_data  output  VLEN  merged data.
- hazard_address  input  5  issue-stage query.
- hazard_hit  output  1  query matches any occupied entry.
- occupancy  output  clog2(DEPTH)+1  entries held.

Behaviour:
- Element count: N = VLEN/32 when in_sew=0, VLEN/64 when in_sew=1. Element i occupies bits [i*SEW +: SEW].
- Merge, combinational at input, per element i:
  - active if i < in_vl and (in_vm or in_v0[i]) → in_vd slice.
  - inactive body element (i < in_vl, masked off) → in_vd_old slice.
  - tail element (i ≥ in_vl) → in_vd_old slice; all-ones only as defined under Optional Feature.
- in_vl > N is clamped to N.
- Push: on in_valid & in_ready, the merged data and in_vd_address are written at the tail pointer.
  - in_vl = 0: handshake completes, nothing enqueued, occupancy unchanged.
- in_ready = (occupancy < DEPTH). It is derived from registered state only; no combinational path from wb_ready.
- Pop: on wb_valid & wb_ready, the head pointer advances. wb_valid = (occupancy ≠ 0). wb_address and wb_data come from the head entry; wb_data is held stable while wb_valid & !wb_ready.
- Latency: a result accepted into an empty FIFO appears on wb_valid the next cycle.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. This is legal only when the FIFO is not full, because in_ready is low when full.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by occupancy.
- hazard_hit is combinational over the occupied entries: asserted if any occupied entry's address equals hazard_address. An entry popped in the current cycle still counts as occupied.
- Reset (n_reset low at a clock edge):
  - occupancy, pointers and all entry valid state clear.
  - wb_valid=0, hazard_hit=0, in_ready=1 the following cycle.
  - wb_address=0, wb_data=0.
  - In-flight entries are discarded; a push in the reset cycle is ignored.

Optional Feature:
- Macro: DRAGONFANG_WB_TAIL_AGNOSTIC_EN.
- Defined: when in_vta=1, tail elements are written as all-ones. Masked-off body elements still keep old values.
- Undefined: in_vta is ignored and tail elements are always undisturbed (in_vd_old).

Test Plan (VLEN=64, DEPTH=2):
- SEW32, vl=2, vm=1, vd=0x11112222_33334444, old=0xAAAAAAAA_BBBBBBBB → next cycle wb_valid=1, wb_data=0x11112222_33334444, wb_address matches the input.
- SEW32, vl=2, vm=0, v0=2'b01, same data → wb_data=0xAAAAAAAA_33334444.
- SEW32, vl=1, vta=1, vm=1 → macro defined: wb_data=0xFFFFFFFF_33334444; macro undefined: wb_data=0xAAAAAAAA_33334444.
- Three back-to-back pushes (addresses 3, 4, 5) with wb_ready=0 → occupancy=2, in_ready=0, third push stalls; hazard_address=4 gives hazard_hit=1, hazard_address=5 gives 0. Raise wb_ready → entries drain in order 3, 4, then 5.
- vl=0 push → no wb_valid, occupancy stays 0.
- With 2 entries held, assert n_reset low for one cycle → occupancy=0, wb_valid=0, in_ready=1, hazard_hit=0 on the next cycle.
